// File: rtl/uart_defs_pkg.sv
// Shared UART transmit definitions: shift FSM states, frame constants and
// the clock-counter width helper.
package uart_defs_pkg;

   localparam int unsigned CLKS_PER_BIT_DEFAULT = 54;
   localparam int unsigned FRAME_BITS           = 10;
   localparam int unsigned DATA_BITS            = FRAME_BITS - 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 3) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; pushes while full are ignored.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data_c,
   output logic                   full_c,
   output logic                   empty_c,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full_c     = (count == CW'(DEPTH));
   assign empty_c    = (count == '0);
   assign push_ok    = push && !full_c;
   assign pop_ok     = pop && !empty_c;
   assign pop_data_c = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Storage needs no reset; only the pointers define valid contents.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: input FIFO feeding a start/data/stop shift
// FSM that chains queued bytes back-to-back without idle gaps.
module uart_tx_buffered
   import uart_defs_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Tx_DV,
   input  logic [7:0] i_Tx_Byte,
   output logic       o_Tx_Ready,
   output logic       o_Tx_Overflow,
   output logic       o_Tx_Active,
   output logic       o_Tx_Serial,
   output logic       o_Tx_Done
);

   localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
   localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   tx_state_e        state_q,   state_d;
   logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
   logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
   logic [7:0]       data_q,    data_d;
   logic             serial_q,  serial_d;
   logic             active_q,  active_d;
   logic             done_q,    done_d;
   logic             overflow_q;

   logic             pop_c;
   logic             bit_last_c;
   logic [7:0]       fifo_data_c;
   logic             fifo_full_c;
   logic             fifo_empty_c;
   logic [CW-1:0]    fifo_count;

   uart_tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (i_Clock),
      .rst        (i_Reset),
      .push       (i_Tx_DV),
      .push_data  (i_Tx_Byte),
      .pop        (pop_c),
      .pop_data_c (fifo_data_c),
      .full_c     (fifo_full_c),
      .empty_c    (fifo_empty_c),
      .count      (fifo_count)
   );

   assign o_Tx_Ready    = (fifo_count != CW'(FIFO_DEPTH));
   assign o_Tx_Overflow = overflow_q;
   assign o_Tx_Active   = active_q;
   assign o_Tx_Serial   = serial_q;
   assign o_Tx_Done     = done_q;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q    <= ST_IDLE;
         clk_cnt_q  <= '0;
         bit_idx_q  <= '0;
         data_q     <= '0;
         serial_q   <= 1'b1;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_idx_q  <= bit_idx_d;
         data_q     <= data_d;
         serial_q   <= serial_d;
         active_q   <= active_d;
         done_q     <= done_d;
         overflow_q <= i_Tx_DV && fifo_full_c;
      end
   end

   assign bit_last_c = (clk_cnt_q == CNT_LAST);

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_idx_d = bit_idx_q;
      data_d    = data_q;
      serial_d  = serial_q;
      active_d  = active_q;
      done_d    = 1'b0;
      pop_c     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            serial_d = 1'b1;
            active_d = 1'b0;
            if (!fifo_empty_c) begin
               pop_c     = 1'b1;
               data_d    = fifo_data_c;
               clk_cnt_d = '0;
               bit_idx_d = '0;
               serial_d  = 1'b0;
               active_d  = 1'b1;
               state_d   = ST_START;
            end
         end

         ST_START: begin
            if (bit_last_c) begin
               clk_cnt_d = '0;
               serial_d  = data_q[0];
               state_d   = ST_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end

         ST_DATA: begin
            if (bit_last_c) begin
               clk_cnt_d = '0;
               if (bit_idx_q == IDX_LAST) begin
                  serial_d = 1'b1;
                  state_d  = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
                  serial_d  = data_q[bit_idx_q + IDX_W'(1)];
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end

         // A waiting byte starts on the very edge the stop bit ends.
         ST_STOP: begin
            if (bit_last_c) begin
               clk_cnt_d = '0;
               done_d    = 1'b1;
               if (!fifo_empty_c) begin
                  pop_c     = 1'b1;
                  data_d    = fifo_data_c;
                  bit_idx_d = '0;
                  serial_d  = 1'b0;
                  state_d   = ST_START;
               end else begin
                  active_d = 1'b0;
                  state_d  = ST_IDLE;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d   = ST_IDLE;
            clk_cnt_d = '0;
            bit_idx_d = '0;
            serial_d  = 1'b1;
            active_d  = 1'b0;
         end
      endcase
   end

endmodule
